tube_bcd_writer: RTL and testbench



---
 rtl/tube_bcd_writer_if.sv | 30 +++
 rtl/tube_bcd_writer.sv | 209 ++++++++++++++++++++
 tb/tb_tube_bcd_writer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tube_bcd_writer_if.sv
// Request/response bundle between the CPU MMIO store path and tube_bcd_writer.
//   iMmioWrite        one-cycle store strobe
//   iMmioMode         0 = hex passthrough, 1 = unsigned decimal
//   iMmioData         32-bit value to display
//   oBusy             writer busy (active or holding a pending request)
//   oOverrun          sticky: a pending request was overwritten
//   oDoTubeWrite      tube write strobe
//   oTubeAddress      2'b00 = low half, 2'b10 = high half
//   oTubeDataToWrite  halfword for the tube
// master = CPU side, slave = tube_bcd_writer.
interface tube_bcd_writer_if;
  logic        iMmioWrite;
  logic        iMmioMode;
  logic [31:0] iMmioData;
  logic        oBusy;
  logic        oOverrun;
  logic        oDoTubeWrite;
  logic [1:0]  oTubeAddress;
  logic [15:0] oTubeDataToWrite;

  modport master (
    output iMmioWrite, iMmioMode, iMmioData,
    input  oBusy, oOverrun, oDoTubeWrite, oTubeAddress, oTubeDataToWrite
  );

  modport slave (
    input  iMmioWrite, iMmioMode, iMmioData,
    output oBusy, oOverrun, oDoTubeWrite, oTubeAddress, oTubeDataToWrite
  );
endinterface

// File: rtl/tube_bcd_writer.sv
// Feeds the digital-tube driver from CPU MMIO stores. Each store carries a 32-bit
// value in hex or unsigned-decimal mode; decimal values are converted to 8 packed
// BCD digits by a 32-cycle sequential double-dabble. The result goes out as two
// tube writes: low halfword to address 2'b00, then high halfword to 2'b10.
// Decimal values above MAX_DEC are shown as ERR_PATTERN on both halves.
// A one-entry pending slot absorbs a store arriving while busy (last writer wins,
// oOverrun records an overwrite).
// Ports:
//   iCpuClock       CPU clock
//   iCpuReset       asynchronous active-high reset
//   bus             tube_bcd_writer_if.slave (MMIO request in, tube write out)
//   oLastDisplayed  last 32-bit pattern written (only with TUBE_BCD_READBACK_EN)
// Optional feature macro: TUBE_BCD_READBACK_EN.
module tube_bcd_writer #(
  parameter logic [31:0] MAX_DEC     = 32'd99_999_999,
  parameter logic [15:0] ERR_PATTERN = 16'hEEEE
) (
  input  logic               iCpuClock,
  input  logic               iCpuReset,
  tube_bcd_writer_if.slave   bus
`ifdef TUBE_BCD_READBACK_EN
  ,
  output logic [31:0]        oLastDisplayed
`endif
);

  typedef enum logic [1:0] {StIdle, StConv, StWrLo, StWrHi} state_e;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_mode_q, pend_mode_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        overrun_q, overrun_d;
  logic        strobe_q, strobe_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;

  logic        start_req;
  logic        start_mode;
  logic [31:0] start_data;
  logic [31:0] bcd_adj;
  logic [31:0] conv_bcd;
  logic [31:0] conv_shift;

  // Add 3 to every digit >= 5 so the following shift carries correctly into the next digit.
  function automatic logic [31:0] dabble_adjust(input logic [31:0] b);
    logic [31:0] r;
    r = b;
    for (int i = 0; i < 8; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    bcd_adj    = dabble_adjust(bcd_q);
    conv_bcd   = {bcd_adj[30:0], shift_q[31]};
    conv_shift = {shift_q[30:0], 1'b0};
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    pend_data_d  = pend_data_q;
    overrun_d    = overrun_q;
    start_req    = 1'b0;
    start_mode   = 1'b0;
    start_data   = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.iMmioWrite) begin
          start_req  = 1'b1;
          start_mode = bus.iMmioMode;
          start_data = bus.iMmioData;
        end
      end
      StConv, StWrLo: begin
        if (state_q == StConv) begin
          shift_d = conv_shift;
          bcd_d   = conv_bcd;
          cnt_d   = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            result_d = conv_bcd;
            state_d  = StWrLo;
          end
        end else begin
          state_d = StWrHi;
        end
        if (bus.iMmioWrite) begin
          if (pend_valid_q) overrun_d = 1'b1;
          pend_valid_d = 1'b1;
          pend_mode_d  = bus.iMmioMode;
          pend_data_d  = bus.iMmioData;
        end
      end
      StWrHi: begin
        if (pend_valid_q) begin
          // Chain straight into the pending request; a same-cycle store refills the slot.
          start_req    = 1'b1;
          start_mode   = pend_mode_q;
          start_data   = pend_data_q;
          pend_valid_d = bus.iMmioWrite;
          if (bus.iMmioWrite) begin
            pend_mode_d = bus.iMmioMode;
            pend_data_d = bus.iMmioData;
          end
        end else if (bus.iMmioWrite) begin
          start_req  = 1'b1;
          start_mode = bus.iMmioMode;
          start_data = bus.iMmioData;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_req) begin
      if (!start_mode) begin
        result_d = start_data;
        state_d  = StWrLo;
      end else if (start_data <= MAX_DEC) begin
        shift_d = start_data;
        bcd_d   = '0;
        cnt_d   = 5'd31;
        state_d = StConv;
      end else begin
        result_d = {ERR_PATTERN, ERR_PATTERN};
        state_d  = StWrLo;
      end
    end
  end

  // Tube outputs are registered from the next state so they change on the entering edge.
  always_comb begin
    strobe_d = (state_d == StWrLo) || (state_d == StWrHi);
    addr_d   = addr_q;
    data_d   = data_q;
    if (state_d == StWrLo) begin
      addr_d = 2'b00;
      data_d = result_d[15:0];
    end else if (state_d == StWrHi) begin
      addr_d = 2'b10;
      data_d = result_d[31:16];
    end
  end

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= 1'b0;
      pend_data_q  <= '0;
      overrun_q    <= 1'b0;
      strobe_q     <= 1'b0;
      addr_q       <= 2'b00;
      data_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      pend_data_q  <= pend_data_d;
      overrun_q    <= overrun_d;
      strobe_q     <= strobe_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign bus.oBusy            = (state_q != StIdle) || pend_valid_q;
  assign bus.oOverrun         = overrun_q;
  assign bus.oDoTubeWrite     = strobe_q;
  assign bus.oTubeAddress     = addr_q;
  assign bus.oTubeDataToWrite = data_q;

`ifdef TUBE_BCD_READBACK_EN
  logic [31:0] last_q;

  // Captured on the edge entering WR_HI, when the full pattern is committed.
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      last_q <= '0;
    end else if (state_q == StWrLo) begin
      last_q <= result_q;
    end
  end

  assign oLastDisplayed = last_q;
`endif

endmodule

// File: tb/tb_tube_bcd_writer.sv
module tb_tube_bcd_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tube_bcd_writer_if bus ();

`ifdef TUBE_BCD_READBACK_EN
  logic [31:0] last_disp;
`endif

  tube_bcd_writer dut (
    .iCpuClock      (clk),
    .iCpuReset      (rst),
    .bus            (bus)
`ifdef TUBE_BCD_READBACK_EN
    ,
    .oLastDisplayed (last_disp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [31:0] data;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    int          lat;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic early;
    @(negedge clk);
    bus.iMmioWrite = 1'b1;
    bus.iMmioMode  = v.mode;
    bus.iMmioData  = v.data;
    @(posedge clk);
    #1 bus.iMmioWrite = 1'b0;
    early = 1'b0;
    for (int k = 0; k < v.lat; k++) begin
      @(negedge clk);
      if (bus.oDoTubeWrite) early = 1'b1;
    end
    check("no_early_strobe", {31'd0, early}, 32'd0);
    @(negedge clk);
    check("lo_strobe", {31'd0, bus.oDoTubeWrite}, 32'd1);
    check("lo_addr", {30'd0, bus.oTubeAddress}, 32'd0);
    check("lo_data", {16'd0, bus.oTubeDataToWrite}, {16'd0, v.exp_lo});
    check("busy_mid", {31'd0, bus.oBusy}, 32'd1);
    @(negedge clk);
    check("hi_strobe", {31'd0, bus.oDoTubeWrite}, 32'd1);
    check("hi_addr", {30'd0, bus.oTubeAddress}, 32'd2);
    check("hi_data", {16'd0, bus.oTubeDataToWrite}, {16'd0, v.exp_hi});
    @(negedge clk);
    check("idle_strobe", {31'd0, bus.oDoTubeWrite}, 32'd0);
    check("idle_busy", {31'd0, bus.oBusy}, 32'd0);
`ifdef TUBE_BCD_READBACK_EN
    check("readback", last_disp, {v.exp_hi, v.exp_lo});
`endif
  endtask

  initial begin
    int          n;
    int          ks[8];
    logic [1:0]  as[8];
    logic [15:0] ds[8];
    logic        seen;

    vecs[0] = '{1'b1, 32'd12345678,   16'h5678, 16'h1234, 32};
    vecs[1] = '{1'b0, 32'hDEADBEEF,   16'hBEEF, 16'hDEAD, 0};
    vecs[2] = '{1'b1, 32'd100000000,  16'hEEEE, 16'hEEEE, 0};
    vecs[3] = '{1'b1, 32'd0,          16'h0000, 16'h0000, 32};
    vecs[4] = '{1'b1, 32'd99999999,   16'h9999, 16'h9999, 32};
    vecs[5] = '{1'b1, 32'd42,         16'h0042, 16'h0000, 32};
    vecs[6] = '{1'b1, 32'hFFFFFFFF,   16'hEEEE, 16'hEEEE, 0};
    vecs[7] = '{1'b0, 32'h12345678,   16'h5678, 16'h1234, 0};
    vecs[8] = '{1'b1, 32'd10000000,   16'h0000, 16'h1000, 32};

    bus.iMmioWrite = 1'b0;
    bus.iMmioMode  = 1'b0;
    bus.iMmioData  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.oBusy}, 32'd0);
    check("rst_overrun", {31'd0, bus.oOverrun}, 32'd0);
    check("rst_strobe", {31'd0, bus.oDoTubeWrite}, 32'd0);
    check("rst_addr", {30'd0, bus.oTubeAddress}, 32'd0);
    check("rst_data", {16'd0, bus.oTubeDataToWrite}, 32'd0);
`ifdef TUBE_BCD_READBACK_EN
    check("rst_readback", last_disp, 32'd0);
`endif

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Three back-to-back stores: dec 1 starts, hex 2 is overwritten by hex 3.
    @(negedge clk);
    bus.iMmioWrite = 1'b1;
    bus.iMmioMode  = 1'b1;
    bus.iMmioData  = 32'd1;
    @(negedge clk);
    bus.iMmioMode  = 1'b0;
    bus.iMmioData  = 32'd2;
    @(negedge clk);
    bus.iMmioData  = 32'd3;
    @(negedge clk);
    bus.iMmioWrite = 1'b0;
    check("b2b_overrun", {31'd0, bus.oOverrun}, 32'd1);
    n = 0;
    for (int k = 3; k < 50; k++) begin
      @(negedge clk);
      if (bus.oDoTubeWrite && n < 8) begin
        ks[n] = k;
        as[n] = bus.oTubeAddress;
        ds[n] = bus.oTubeDataToWrite;
        n++;
      end
    end
    check("b2b_count", n, 4);
    if (n == 4) begin
      check("b2b_k0", ks[0], 32);
      check("b2b_d0", {16'd0, ds[0]}, 32'h0001);
      check("b2b_a0", {30'd0, as[0]}, 32'd0);
      check("b2b_d1", {16'd0, ds[1]}, 32'h0000);
      check("b2b_a1", {30'd0, as[1]}, 32'd2);
      check("b2b_k2_no_gap", ks[2], 34);
      check("b2b_d2", {16'd0, ds[2]}, 32'h0003);
      check("b2b_a2", {30'd0, as[2]}, 32'd0);
      check("b2b_d3", {16'd0, ds[3]}, 32'h0000);
      check("b2b_a3", {30'd0, as[3]}, 32'd2);
    end
    check("b2b_idle", {31'd0, bus.oBusy}, 32'd0);
    check("b2b_overrun_sticky", {31'd0, bus.oOverrun}, 32'd1);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bus.iMmioWrite = 1'b1;
    bus.iMmioMode  = 1'b1;
    bus.iMmioData  = 32'd12345678;
    @(negedge clk);
    bus.iMmioWrite = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.oBusy}, 32'd0);
    check("arst_overrun", {31'd0, bus.oOverrun}, 32'd0);
    check("arst_strobe", {31'd0, bus.oDoTubeWrite}, 32'd0);
    check("arst_addr", {30'd0, bus.oTubeAddress}, 32'd0);
    check("arst_data", {16'd0, bus.oTubeDataToWrite}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.oDoTubeWrite) seen = 1'b1;
    end
    check("arst_no_strobe", {31'd0, seen}, 32'd0);
    run_vec(vecs[1]);
    run_vec(vecs[5]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
